mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's load/store traffic.
- The CPU datapath issues one word, halfword or byte request at a time. This block services it against an internal word-organised RAM and returns one response per request.
- Sub-word stores are done as read-modify-write inside the block, so the CPU never has to merge bytes itself.
- Misaligned and out-of-range accesses return an error response. The CPU's controller uses it to raise an exception through its EPC path.

Parameters:
- DEPTH, 256: number of 32-bit words in the RAM. Valid word index range is 0..DEPTH-1.
- AW, 8: word-index width, equal to ceil(log2(DEPTH)).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 halfword, 10 byte; 11 is reserved and treated as an error.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the sub-word value sits in the low bits.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  load data, zero-extended, lane-aligned to bit 0; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, out-of-range or reserved size.

Behaviour:
- Reset values: FSM returns to IDLE; resp_valid=0, resp_rdata=0, resp_err=0; req_ready=1 from the first cycle after reset deasserts. RAM contents are not cleared.
- Handshake: a request is accepted when req_valid and req_ready are both high at a rising edge. On acceptance, addr, size, write flag and wdata are latched. Request inputs are ignored outside IDLE.
- Byte order is little-endian: addr[1:0]=0 selects bits 7:0.
- Error check at acceptance, in this order:
  - size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= DEPTH.
- FSM states:
  - IDLE: on accept, go to ERR if the check fails, WR for a word store, and RD otherwise.
  - WR: write req_wdata to RAM[addr[AW+1:2]]; resp_valid=1, resp_err=0, resp_rdata=0; then IDLE.
  - RD: issue a synchronous RAM read; then RESP for a load, MERGE for a sub-word store.
  - RESP: extract the addressed lane from the RAM word and zero-extend it onto resp_rdata; resp_valid=1; then IDLE.
  - MERGE: replace the addressed byte or halfword lane of the RAM word with wdata[7:0] or wdata[15:0], write it back, and pulse resp_valid=1; then IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0, RAM untouched; then IDLE.
- Latency, counted from the acceptance edge:
  - word store: response in the next cycle;
  - error: response in the next cycle;
  - load: response 2 cycles later;
  - sub-word store: response 2 cycles later.
- Throughput: after any response the block is back in IDLE, so a new request can be accepted on the edge that ends the response cycle.
- resp_valid is high for exactly one cycle per accepted request. resp_rdata and resp_err are 0 whenever resp_valid=0.
- Reset mid-operation: FSM goes to IDLE immediately and no response is issued.
  - A pending MERGE or WR write is suppressed if reset is high in that cycle.
  - A word already written stays written.
- Simultaneous requests: only one request is outstanding at a time; there is no queue.

Decomposition:
- Shared package mem_resp_pkg holds:
  - size encodings SZ_WORD, SZ_HALF, SZ_BYTE, SZ_RSVD;
  - the state enum IDLE, RD, RESP, MERGE, WR, ERR;
  - the lane-extract and lane-merge functions.
- One sub-module, resp_word_ram: DEPTH x 32 RAM with a synchronous read port and a synchronous write port, no reset.
- FSM, latching and lane logic live in mem_responder.

Test Plan:
- Word store then load: store 0xDEADBEEF to 0x8 → response 1 cycle after accept with err=0. Load word 0x8 → response 2 cycles after accept, rdata=0xDEADBEEF.
- Sub-word store and loads:
  - store byte 0xAA to 0x9 → a word load of 0x8 returns 0xDEADAAEF;
  - byte load of 0xB → 0x000000DE;
  - half load of 0xA → 0x0000DEAD.
- Misalignment:
  - half load at 0x3 → err=1 one cycle after accept, rdata=0;
  - word store of 0x12345678 to 0x6 → err=1, and a word load of 0x4 is unchanged.
- Range and reserved size, with DEPTH=256:
  - word load at 0x400 → err=1;
  - size=11 at 0x0 → err=1.
- Handshake: hold req_valid high with two back-to-back requests. Require req_ready=0 in RD, RESP, MERGE, WR and ERR; the second request is accepted only on the edge ending the first response; exactly two resp_valid pulses.
- Reset mid-operation: assert reset during the MERGE cycle of a byte store of 0x55 to 0x8. Require no resp_valid, req_ready=1 after release, and a word load of 0x8 that returns the pre-store value.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared encodings, FSM state type and lane helpers for the load/store responder.
package mem_resp_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RESP,
        MERGE,
        WR,
        ERR
    } state_t;

    // Pull the addressed little-endian lane down to bit 0, zero-extended.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_HALF: r = off[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
            SZ_BYTE: begin
                case (off)
                    2'd0:    r = {24'h0, word[7:0]};
                    2'd1:    r = {24'h0, word[15:8]};
                    2'd2:    r = {24'h0, word[23:16]};
                    default: r = {24'h0, word[31:24]};
                endcase
            end
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size);
        logic [31:0] r;
        r = wdata;
        case (size)
            SZ_HALF: r = off[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
            SZ_BYTE: begin
                case (off)
                    2'd0:    r = {word[31:8], wdata[7:0]};
                    2'd1:    r = {word[31:16], wdata[7:0], word[7:0]};
                    2'd2:    r = {word[31:24], wdata[7:0], word[15:0]};
                    default: r = {wdata[7:0], word[23:0]};
                endcase
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/resp_word_ram.sv
// DEPTH x 32 word RAM: one synchronous read port, one synchronous write port, contents not reset.
module resp_word_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder; sub-word stores are read-modify-write on the word RAM.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    state_t        r_state;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_write;
    logic [31:0]   r_wdata;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [31:0]   r_resp_rdata;

    logic          w_accept;
    logic          w_err;
    logic          w_ram_we;
    logic          w_ram_re;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_rdata;

    assign req_ready  = (r_state == IDLE);
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    always_comb begin
        w_err = 1'b0;
        if (req_size == SZ_RSVD)
            w_err = 1'b1;
        else if (req_size == SZ_HALF && req_addr[0])
            w_err = 1'b1;
        else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            w_err = 1'b1;
        else if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))
            w_err = 1'b1;
    end

    // Gating the write with reset lets a reset in the WR/MERGE cycle cancel the store.
    assign w_ram_we    = (r_state == WR || r_state == MERGE) && !reset;
    assign w_ram_re    = (r_state == RD);
    assign w_ram_wdata = (r_state == MERGE) ? lane_merge(w_ram_rdata, r_wdata, r_off, r_size)
                                            : r_wdata;

    resp_word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_ram_we),
        .i_waddr (r_idx),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (r_idx),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx   <= req_addr[AW+1:2];
                        r_off   <= req_addr[1:0];
                        r_size  <= req_size;
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                        if (w_err)
                            r_state <= ERR;
                        else if (req_write && req_size == SZ_WORD)
                            r_state <= WR;
                        else
                            r_state <= RD;
                    end
                end
                RD: r_state <= r_write ? MERGE : RESP;
                RESP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= lane_extract(w_ram_rdata, r_off, r_size);
                    r_state      <= IDLE;
                end
                MERGE, WR: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= IDLE;
                end
                ERR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
